filter_cmd_sequencer: RTL and testbench
=======================================

Name: filter_cmd_sequencer

Overview:
UART-side command sequencer for the masked 2D WOS filter. It consumes received bytes from the UART receiver and parses the one-letter command protocol ('h','w','n','r','m','s'). It holds the filter configuration registers, validates them, and issues a single-cycle start to the filter datapath. It tracks the filter run to completion and queues one-byte replies for the UART transmitter.

Parameters:
MAX_N, 7, largest supported kernel side; the mask holds MAX_N*MAX_N bits
DIM_W, 8, width of the height/width/n/rank registers
MASK_BYTES, 7, ceil(MAX_N*MAX_N/8); bytes in a full mask transfer
TIMEOUT_CYCLES, 1000000, idle cycles allowed between argument bytes before the command is aborted

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous reset, active-high
rx_valid  in  1  one-cycle strobe; a received byte is present on rx_data
rx_data  in  8  received byte
filter_busy  in  1  datapath is processing
filter_done  in  1  one-cycle strobe; datapath has finished the frame
cfg_height  out  DIM_W  image height
cfg_width  out  DIM_W  image width
cfg_n  out  DIM_W  kernel side
cfg_rank  out  DIM_W  order-statistic index, 1-based
cfg_mask  out  MAX_N*MAX_N  kernel mask; bit i is kernel position i in row-major order
start  out  1  one-cycle start pulse to the datapath
err  out  1  one-cycle error strobe
err_code  out  3  code valid with err: 1 unknown cmd, 2 bad arg, 3 timeout, 4 busy, 5 start check failed
tx_valid  out  1  reply byte is pending
tx_data  out  8  reply byte: 'k' ack, 'e' error, 'd' done
tx_ready  in  1  transmitter accepts the byte when tx_valid and tx_ready are both high

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): all cfg_* = 0, start=0, err=0, err_code=0, tx_valid=0, tx_data=0, state=IDLE, timeout counter=0.
- States: IDLE, ARG, MASK, CHECK, RUN.
- IDLE: byte 'h','w','n','r' -> latch the command, go to ARG. Byte 'm' -> clear cfg_mask, byte index=0, go to MASK. Byte 's' -> bit index=0, count=0, go to CHECK. Any other byte -> err code 1, reply 'e', stay in IDLE.
- ARG: the next byte is written to the latched register, reply 'k', return to IDLE.
  - 'h' or 'w' with value 0 -> register unchanged, err code 2, reply 'e'.
  - 'n' with value 0, an even value, or a value >MAX_N -> register unchanged, err code 2, reply 'e'.
  - 'r' accepts any value here; it is checked at start.
- MASK: byte k loads cfg_mask[8k+7:8k]. Bits at index >= MAX_N*MAX_N are discarded. Transfer length L = ceil(cfg_n*cfg_n/8), using the cfg_n current when 'm' was received. After byte L-1, reply 'k' and return to IDLE. If cfg_n=0, L=1.
- Timeout: in ARG or MASK, the counter increments every cycle without rx_valid and resets on rx_valid. On reaching TIMEOUT_CYCLES -> err code 3, reply 'e', go to IDLE. A partial mask is kept as loaded.
- CHECK: one mask bit per cycle over indices 0..MAX_N*MAX_N-1. Count a bit only if it is set and its index < cfg_n*cfg_n. On the cycle after the last index, evaluate the start check:
  - pass if cfg_height>=cfg_n, cfg_width>=cfg_n, cfg_n!=0, and 1<=cfg_rank<=count;
  - pass -> start=1 for one cycle, reply 'k', go to RUN;
  - fail -> err code 5, reply 'e', go to IDLE.
  - Latency: start rises exactly MAX_N*MAX_N+1 cycles after the cycle in which 's' was sampled.
  - Bytes received during CHECK are dropped with err code 4; no reply.
- RUN: cfg_* are frozen. Any rx byte -> err code 4, dropped, no reply. filter_done -> reply 'd', go to IDLE. If filter_done coincides with rx_valid, done wins and the byte is dropped with err code 4.
- Reply buffer: holds one entry. A reply raised while tx_valid=1 and tx_ready=0 is discarded. A reply raised in the same cycle that the pending byte is accepted is loaded (tx_valid stays 1).
- rst asserted mid-command or mid-run returns everything to reset values. start is never issued on the reset cycle.
- Widths: cfg_n*cfg_n is computed at 2*DIM_W bits. The popcount is ceil(log2(MAX_N*MAX_N+1)) bits. cfg_rank is compared zero-extended.

Decomposition:
- Shared package masked_filter_pkg:
  - command byte constants CMD_H/W/N/R/M/S;
  - reply constants RSP_ACK/ERR/DONE;
  - err_code enum;
  - state typedef;
  - MAX_N default.
- One sub-module: reply_slot, the one-entry valid/ready holding register with the discard-when-full rule. Popcount and the FSM stay inline.

Test Plan:
- Configure: h,22, w,22, n,3, r,5, m,0xFF,0x01, then s. Expect:
  - cfg_height=22, cfg_width=22, cfg_n=3, cfg_rank=5, cfg_mask=0x1FF;
  - five 'k' replies before s, a sixth 'k' with start;
  - start exactly 50 cycles after 's' (MAX_N=7);
  - filter_done -> 'd'.
- Bad args: n,4 -> err code 2, 'e', cfg_n unchanged. h,0 -> code 2. Byte 'x' in IDLE -> code 1, 'e'.
- Rank check: n=3, mask 0x007 (3 bits), r=4, s -> no start, err code 5, 'e'. Then r=3, s -> start.
- Busy: during RUN send 'h' -> err code 4, cfg_height unchanged, no reply. Drive filter_done and rx_valid together -> 'd', byte dropped with code 4.
- Timeout (TIMEOUT_CYCLES=100): 'm', one byte, then idle 100 cycles -> err code 3, 'e', state IDLE, low mask byte retained.
- Reply backpressure: hold tx_ready=0, send h,10 then w,10 -> only the first 'k' is transmitted after release; both registers are updated. Reset asserted mid-MASK -> all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/masked_filter_pkg.sv
// Shared definitions for the masked 2D WOS filter command path: command and
// reply byte values, error codes, sequencer states and the default kernel size.
package masked_filter_pkg;

  localparam int unsigned MAX_N_DEF = 7;

  // Command letters received over the UART
  localparam logic [7:0] CMD_H = 8'h68;  // 'h' image height
  localparam logic [7:0] CMD_W = 8'h77;  // 'w' image width
  localparam logic [7:0] CMD_N = 8'h6E;  // 'n' kernel side
  localparam logic [7:0] CMD_R = 8'h72;  // 'r' rank
  localparam logic [7:0] CMD_M = 8'h6D;  // 'm' mask transfer
  localparam logic [7:0] CMD_S = 8'h73;  // 's' start

  // Reply letters sent back over the UART
  localparam logic [7:0] RSP_ACK  = 8'h6B;  // 'k'
  localparam logic [7:0] RSP_ERR  = 8'h65;  // 'e'
  localparam logic [7:0] RSP_DONE = 8'h64;  // 'd'

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_UNKNOWN = 3'd1,
    ERR_BAD_ARG = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_BUSY    = 3'd4,
    ERR_START   = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARG   = 3'd1,
    ST_MASK  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RUN   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/reply_slot.sv
// One-entry reply holding register between the sequencer and the UART
// transmitter. A new reply is dropped when the slot is full and the pending
// byte is not being accepted in the same cycle.
//   clk, rst       : clock, synchronous active-high reset
//   push_i         : one-cycle request to queue push_data_i
//   push_data_i    : reply byte to queue
//   tx_ready_i     : transmitter accepts the pending byte
//   tx_valid_o     : a reply byte is pending
//   tx_data_o      : pending reply byte
module reply_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       tx_ready_i,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  // Accept frees the slot; a push refills it only if it is free or draining
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && tx_ready_i) begin
      valid_d = 1'b0;
    end
    if (push_i && (!valid_q || tx_ready_i)) begin
      valid_d = 1'b1;
      data_d  = push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign tx_valid_o = valid_q;
  assign tx_data_o  = data_q;

endmodule

// File: rtl/filter_cmd_sequencer.sv
// UART-side command sequencer for the masked 2D WOS filter. Parses the
// one-letter command protocol, holds and validates the filter configuration,
// issues a one-cycle start to the datapath, tracks the run and queues replies.
//   clk, rst                 : clock, synchronous active-high reset
//   rx_valid, rx_data        : received byte strobe and value
//   filter_busy, filter_done : datapath status and completion strobe
//   cfg_height/width/n/rank  : configuration registers
//   cfg_mask                 : kernel mask, bit i = row-major kernel position i
//   start                    : one-cycle start pulse to the datapath
//   err, err_code            : one-cycle error strobe and its code
//   tx_valid, tx_data        : pending reply byte ('k', 'e', 'd')
//   tx_ready                 : transmitter accepts the pending byte
module filter_cmd_sequencer
  import masked_filter_pkg::*;
#(
  parameter int unsigned MAX_N          = MAX_N_DEF,
  parameter int unsigned DIM_W          = 8,
  parameter int unsigned MASK_BYTES     = (MAX_N * MAX_N + 7) / 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     filter_busy,
  input  logic                     filter_done,
  output logic [DIM_W-1:0]         cfg_height,
  output logic [DIM_W-1:0]         cfg_width,
  output logic [DIM_W-1:0]         cfg_n,
  output logic [DIM_W-1:0]         cfg_rank,
  output logic [MAX_N*MAX_N-1:0]   cfg_mask,
  output logic                     start,
  output logic                     err,
  output logic [2:0]               err_code,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready
);

  localparam int unsigned MASK_BITS = MAX_N * MAX_N;
  localparam int unsigned CNT_W     = $clog2(MASK_BITS + 1);
  localparam int unsigned IDX_W     = CNT_W;  // also holds MASK_BITS, the evaluate step
  localparam int unsigned BYTE_W    = $clog2(MASK_BYTES + 1);
  localparam int unsigned SH_W      = BYTE_W + 3;
  localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SQ_W      = 2 * DIM_W;
  localparam int unsigned CMP_W     = (DIM_W > CNT_W) ? DIM_W : CNT_W;

  seq_state_e           state_q;
  logic [7:0]           cmd_q;
  logic [DIM_W-1:0]     cfg_height_q, cfg_width_q, cfg_n_q, cfg_rank_q;
  logic [MASK_BITS-1:0] cfg_mask_q;
  logic                 start_q;
  logic                 err_q;
  err_code_e            err_code_q;
  logic                 reply_req_q;
  logic [7:0]           reply_byte_q;
  logic [TO_W-1:0]      to_cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BYTE_W-1:0]    byte_idx_q;
  logic [BYTE_W-1:0]    mask_len_q;

  logic [SQ_W-1:0]      cfg_sq_c;
  logic [SQ_W-1:0]      cfg_sq_rnd_c;
  logic [BYTE_W-1:0]    mask_len_c;
  logic [SH_W-1:0]      mask_sh_c;
  logic [MASK_BITS-1:0] mask_wr_c;
  logic                 in_kernel_c;
  logic                 start_ok_c;
  logic                 arg_ok_c;
  logic                 timeout_c;
  logic                 unused_busy_c;

  // Completion is tracked through filter_done; busy is informational only
  assign unused_busy_c = filter_busy;

  // Kernel area and mask transfer length, with n=0 still taking one byte
  assign cfg_sq_c     = SQ_W'(cfg_n_q) * SQ_W'(cfg_n_q);
  assign cfg_sq_rnd_c = cfg_sq_c + SQ_W'(7);
  assign mask_len_c   = (cfg_n_q == '0) ? BYTE_W'(1) : BYTE_W'(cfg_sq_rnd_c >> 3);

  // Byte lane merge; bits shifted past the mask width are discarded
  assign mask_sh_c = {byte_idx_q, 3'b000};
  assign mask_wr_c = (cfg_mask_q & ~(MASK_BITS'(8'hFF) << mask_sh_c))
                   | (MASK_BITS'(rx_data) << mask_sh_c);

  assign in_kernel_c = SQ_W'(idx_q) < cfg_sq_c;

  assign start_ok_c = (cfg_height_q >= cfg_n_q) && (cfg_width_q >= cfg_n_q) &&
                      (cfg_n_q != '0) && (cfg_rank_q != '0) &&
                      (CMP_W'(cfg_rank_q) <= CMP_W'(cnt_q));

  assign timeout_c = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Argument validation for the latched command; rank is checked at start
  always_comb begin
    arg_ok_c = 1'b1;
    case (cmd_q)
      CMD_H, CMD_W: arg_ok_c = (rx_data != 8'h00);
      CMD_N:        arg_ok_c = (rx_data != 8'h00) && rx_data[0] &&
                               (32'(rx_data) <= MAX_N);
      default:      arg_ok_c = 1'b1;
    endcase
  end

  // Command FSM with registered configuration, strobes and reply requests
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= 8'h00;
      cfg_height_q <= '0;
      cfg_width_q  <= '0;
      cfg_n_q      <= '0;
      cfg_rank_q   <= '0;
      cfg_mask_q   <= '0;
      start_q      <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      reply_req_q  <= 1'b0;
      reply_byte_q <= 8'h00;
      to_cnt_q     <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      byte_idx_q   <= '0;
      mask_len_q   <= '0;
    end else begin
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      reply_req_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          to_cnt_q <= '0;
          if (rx_valid) begin
            case (rx_data)
              CMD_H, CMD_W, CMD_N, CMD_R: begin
                cmd_q   <= rx_data;
                state_q <= ST_ARG;
              end
              CMD_M: begin
                cfg_mask_q <= '0;
                byte_idx_q <= '0;
                mask_len_q <= mask_len_c;
                state_q    <= ST_MASK;
              end
              CMD_S: begin
                idx_q   <= '0;
                cnt_q   <= '0;
                state_q <= ST_CHECK;
              end
              default: begin
                err_q        <= 1'b1;
                err_code_q   <= ERR_UNKNOWN;
                reply_req_q  <= 1'b1;
                reply_byte_q <= RSP_ERR;
              end
            endcase
          end
        end

        ST_ARG: begin
          if (rx_valid) begin
            to_cnt_q    <= '0;
            state_q     <= ST_IDLE;
            reply_req_q <= 1'b1;
            if (arg_ok_c) begin
              reply_byte_q <= RSP_ACK;
              case (cmd_q)
                CMD_H:   cfg_height_q <= DIM_W'(rx_data);
                CMD_W:   cfg_width_q  <= DIM_W'(rx_data);
                CMD_N:   cfg_n_q      <= DIM_W'(rx_data);
                default: cfg_rank_q   <= DIM_W'(rx_data);
              endcase
            end else begin
              reply_byte_q <= RSP_ERR;
              err_q        <= 1'b1;
              err_code_q   <= ERR_BAD_ARG;
            end
          end else if (timeout_c) begin
            to_cnt_q     <= '0;
            state_q      <= ST_IDLE;
            err_q        <= 1'b1;
            err_code_q   <= ERR_TIMEOUT;
            reply_req_q  <= 1'b1;
            reply_byte_q <= RSP_ERR;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        ST_MASK: begin
          if (rx_valid) begin
            to_cnt_q   <= '0;
            cfg_mask_q <= mask_wr_c;
            if (byte_idx_q == mask_len_q - 1'b1) begin
              state_q      <= ST_IDLE;
              reply_req_q  <= 1'b1;
              reply_byte_q <= RSP_ACK;
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end else if (timeout_c) begin
            // A partially loaded mask is deliberately left in place
            to_cnt_q     <= '0;
            state_q      <= ST_IDLE;
            err_q        <= 1'b1;
            err_code_q   <= ERR_TIMEOUT;
            reply_req_q  <= 1'b1;
            reply_byte_q <= RSP_ERR;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        ST_CHECK: begin
          if (rx_valid) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_BUSY;
          end
          // One mask bit per cycle; idx == MASK_BITS is the evaluate step
          if (idx_q == IDX_W'(MASK_BITS)) begin
            reply_req_q <= 1'b1;
            if (start_ok_c) begin
              start_q      <= 1'b1;
              reply_byte_q <= RSP_ACK;
              state_q      <= ST_RUN;
            end else begin
              err_q        <= 1'b1;
              err_code_q   <= ERR_START;
              reply_byte_q <= RSP_ERR;
              state_q      <= ST_IDLE;
            end
          end else begin
            if (cfg_mask_q[idx_q] && in_kernel_c) begin
              cnt_q <= cnt_q + 1'b1;
            end
            idx_q <= idx_q + 1'b1;
          end
        end

        ST_RUN: begin
          if (rx_valid) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_BUSY;
          end
          if (filter_done) begin
            reply_req_q  <= 1'b1;
            reply_byte_q <= RSP_DONE;
            state_q      <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  reply_slot u_reply_slot (
    .clk         (clk),
    .rst         (rst),
    .push_i      (reply_req_q),
    .push_data_i (reply_byte_q),
    .tx_ready_i  (tx_ready),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data)
  );

  assign cfg_height = cfg_height_q;
  assign cfg_width  = cfg_width_q;
  assign cfg_n      = cfg_n_q;
  assign cfg_rank   = cfg_rank_q;
  assign cfg_mask   = cfg_mask_q;
  assign start      = start_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_filter_cmd_sequencer.sv
// Self-checking bench for filter_cmd_sequencer: replies and error codes are
// predicted into queues as commands are driven and retired by monitors.
module tb_filter_cmd_sequencer;
  import masked_filter_pkg::*;

  localparam int unsigned MAX_N   = 7;
  localparam int unsigned DIM_W   = 8;
  localparam int unsigned LATENCY = MAX_N * MAX_N + 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   rx_valid = 1'b0;
  logic [7:0]             rx_data = 8'h00;
  logic                   filter_busy = 1'b0;
  logic                   filter_done = 1'b0;
  logic [DIM_W-1:0]       cfg_height, cfg_width, cfg_n, cfg_rank;
  logic [MAX_N*MAX_N-1:0] cfg_mask;
  logic                   start, err;
  logic [2:0]             err_code;
  logic                   tx_valid;
  logic [7:0]             tx_data;
  logic                   tx_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int exp_starts = 0;

  logic [7:0] exp_tx[$];
  logic [2:0] exp_err[$];

  filter_cmd_sequencer #(
    .MAX_N          (MAX_N),
    .DIM_W          (DIM_W),
    .MASK_BYTES     (7),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .filter_busy (filter_busy),
    .filter_done (filter_done),
    .cfg_height  (cfg_height),
    .cfg_width   (cfg_width),
    .cfg_n       (cfg_n),
    .cfg_rank    (cfg_rank),
    .cfg_mask    (cfg_mask),
    .start       (start),
    .err         (err),
    .err_code    (err_code),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Issue 's' and measure the cycles from its sampling edge to start
  task automatic send_s(input bit expect_start);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = CMD_S;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    for (int c = 1; c <= LATENCY + 10; c++) begin
      @(posedge clk); #1;
      if (start) begin
        lat = c;
        break;
      end
    end
    if (expect_start) begin
      check_eq("start_latency", 64'(lat), 64'(LATENCY));
      @(posedge clk); #1;
      check_eq("start_one_cycle", 64'(start), 64'd0);
    end else begin
      check_eq("no_start", 64'(lat), 64'd0);
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    filter_done = 1'b1;
    @(posedge clk); #1;
    filter_done = 1'b0;
  endtask

  // Reply scoreboard
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      check_eq("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
      if (exp_tx.size() != 0) check_eq("tx_data", 64'(tx_data), 64'(exp_tx.pop_front()));
    end
  end

  // Error scoreboard
  always @(negedge clk) begin
    if (!rst && err) begin
      check_eq("err_expected", 64'(exp_err.size() != 0), 64'd1);
      if (exp_err.size() != 0) check_eq("err_code", 64'(err_code), 64'(exp_err.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && start) n_starts++;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(3);
    check_eq("rst_height", 64'(cfg_height), 64'd0);
    check_eq("rst_width",  64'(cfg_width),  64'd0);
    check_eq("rst_n",      64'(cfg_n),      64'd0);
    check_eq("rst_rank",   64'(cfg_rank),   64'd0);
    check_eq("rst_mask",   64'(cfg_mask),   64'd0);
    check_eq("rst_start",  64'(start),      64'd0);
    check_eq("rst_err",    64'(err),        64'd0);
    check_eq("rst_code",   64'(err_code),   64'd0);
    check_eq("rst_txv",    64'(tx_valid),   64'd0);
    check_eq("rst_txd",    64'(tx_data),    64'd0);
    rst = 1'b0;
    idle(2);

    // Full configuration then start
    exp_tx.push_back(RSP_ACK); send(CMD_H); send(8'd22);
    exp_tx.push_back(RSP_ACK); send(CMD_W); send(8'd22);
    exp_tx.push_back(RSP_ACK); send(CMD_N); send(8'd3);
    exp_tx.push_back(RSP_ACK); send(CMD_R); send(8'd5);
    exp_tx.push_back(RSP_ACK); send(CMD_M); send(8'hFF); send(8'h01);
    idle(4);
    check_eq("cfg_height", 64'(cfg_height), 64'd22);
    check_eq("cfg_width",  64'(cfg_width),  64'd22);
    check_eq("cfg_n",      64'(cfg_n),      64'd3);
    check_eq("cfg_rank",   64'(cfg_rank),   64'd5);
    check_eq("cfg_mask",   64'(cfg_mask),   64'h1FF);
    check_eq("acks_before_s", 64'(exp_tx.size()), 64'd0);
    exp_tx.push_back(RSP_ACK);
    exp_starts++;
    filter_busy = 1'b1;
    send_s(1'b1);
    idle(3);

    // Busy: bytes during RUN are dropped
    exp_err.push_back(ERR_BUSY);
    send(CMD_H);
    idle(3);
    check_eq("run_height_frozen", 64'(cfg_height), 64'd22);
    exp_tx.push_back(RSP_DONE);
    exp_err.push_back(ERR_BUSY);
    @(posedge clk); #1;
    filter_done = 1'b1;
    rx_valid    = 1'b1;
    rx_data     = CMD_W;
    @(posedge clk); #1;
    filter_done = 1'b0;
    rx_valid    = 1'b0;
    filter_busy = 1'b0;
    idle(4);
    check_eq("run_width_frozen", 64'(cfg_width), 64'd22);

    // Bad arguments and unknown command
    exp_tx.push_back(RSP_ERR); exp_err.push_back(ERR_BAD_ARG);
    send(CMD_N); send(8'd4);
    exp_tx.push_back(RSP_ERR); exp_err.push_back(ERR_BAD_ARG);
    send(CMD_N); send(8'd9);
    exp_tx.push_back(RSP_ERR); exp_err.push_back(ERR_BAD_ARG);
    send(CMD_H); send(8'd0);
    exp_tx.push_back(RSP_ERR); exp_err.push_back(ERR_UNKNOWN);
    send(8'h78);
    idle(4);
    check_eq("bad_n_kept", 64'(cfg_n), 64'd3);
    check_eq("bad_h_kept", 64'(cfg_height), 64'd22);

    // Rank above the mask population fails, then a fitting rank starts
    exp_tx.push_back(RSP_ACK); send(CMD_M); send(8'h07); send(8'h00);
    exp_tx.push_back(RSP_ACK); send(CMD_R); send(8'd4);
    idle(4);
    check_eq("mask_3bits", 64'(cfg_mask), 64'h007);
    exp_tx.push_back(RSP_ERR); exp_err.push_back(ERR_START);
    send_s(1'b0);
    idle(3);
    exp_tx.push_back(RSP_ACK); send(CMD_R); send(8'd3);
    exp_tx.push_back(RSP_ACK);
    exp_starts++;
    send_s(1'b1);
    exp_tx.push_back(RSP_DONE);
    pulse_done();
    idle(4);

    // Timeout mid-mask keeps the loaded byte
    exp_tx.push_back(RSP_ERR); exp_err.push_back(ERR_TIMEOUT);
    send(CMD_M); send(8'hA5);
    idle(98);
    check_eq("no_early_timeout", 64'(exp_err.size()), 64'd1);
    idle(10);
    check_eq("timeout_mask", 64'(cfg_mask), 64'h0A5);
    exp_tx.push_back(RSP_ACK); send(CMD_H); send(8'd9);
    idle(4);
    check_eq("idle_after_timeout", 64'(cfg_height), 64'd9);

    // Reply backpressure: second ack is lost while the first is held
    tx_ready = 1'b0;
    exp_tx.push_back(RSP_ACK);
    send(CMD_H); send(8'd10);
    send(CMD_W); send(8'd10);
    idle(4);
    check_eq("bp_valid", 64'(tx_valid), 64'd1);
    check_eq("bp_data",  64'(tx_data),  64'(RSP_ACK));
    tx_ready = 1'b1;
    idle(4);
    check_eq("bp_drained", 64'(tx_valid), 64'd0);
    check_eq("bp_height", 64'(cfg_height), 64'd10);
    check_eq("bp_width",  64'(cfg_width),  64'd10);

    // Reset asserted mid-mask
    send(CMD_M); send(8'h3C);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mrst_height", 64'(cfg_height), 64'd0);
    check_eq("mrst_n",      64'(cfg_n),      64'd0);
    check_eq("mrst_mask",   64'(cfg_mask),   64'd0);
    check_eq("mrst_txv",    64'(tx_valid),   64'd0);
    check_eq("mrst_start",  64'(start),      64'd0);
    rst = 1'b0;
    idle(2);

    // n=0: mask takes a single byte, start check must fail
    exp_tx.push_back(RSP_ACK); send(CMD_M); send(8'hFF);
    idle(4);
    check_eq("n0_mask", 64'(cfg_mask), 64'hFF);
    exp_tx.push_back(RSP_ERR); exp_err.push_back(ERR_START);
    send_s(1'b0);
    idle(6);

    check_eq("tx_q_drained",  64'(exp_tx.size()),  64'd0);
    check_eq("err_q_drained", 64'(exp_err.size()), 64'd0);
    check_eq("start_count",   64'(n_starts),       64'(exp_starts));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
